// File: rtl/gobou_deserial_vec_pkg.sv
// Shared constants and types for the gobou serial-to-parallel vector collector.
package gobou_deserial_vec_pkg;

   // Signed word width of every lane.
   localparam int DWIDTH = 16;
   // Number of lanes per vector; the port list is laid out for 16.
   localparam int CORE   = 16;
   // Counter and length width; must hold the value CORE, so at least clog2(CORE)+1.
   localparam int LWIDTH = 10;

   typedef logic signed [DWIDTH-1:0] word_t;

   // Occupancy of the two vector slots, encoded as {acc_full, out_valid}.
   // EMPTY    : no completed vector anywhere (acc may hold a partial vector)
   // OUT_ONLY : a vector waits in the output registers
   // BOTH     : output registers busy and a completed vector parked in acc
   typedef enum logic [1:0] {
      EMPTY    = 2'b00,
      OUT_ONLY = 2'b01,
      BOTH     = 2'b11
   } slot_state_t;

endpackage

// File: rtl/gobou_deserial_vec_if.sv
// Serial input stream and parallel output vector bundle of the vector collector.
interface gobou_deserial_vec_if;
   import gobou_deserial_vec_pkg::*;

   logic              in_valid;
   logic              in_ready;
   word_t             in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   word_t             out_data [CORE];
   logic [LWIDTH-1:0] out_len;

   // The collector itself.
   modport slave (
      input  in_valid,
      input  in_data,
      input  flush,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_len
   );

   // Whoever feeds the stream and consumes the vectors.
   modport master (
      output in_valid,
      output in_data,
      output flush,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_len
   );

endinterface

// File: rtl/gobou_deserial_vec.sv
// Serial-to-parallel vector collector: words arrive one per cycle, lane 0 first,
// and are assembled into a CORE-lane vector. An accumulate stage and an output
// stage form a two-slot FIFO so streaming continues while a finished vector waits.
module gobou_deserial_vec
   import gobou_deserial_vec_pkg::*;
(
   input  logic                 clk,
   input  logic                 xrst,
   gobou_deserial_vec_if.slave  bus
);

   slot_state_t       state;
   slot_state_t       state_next;

   logic [LWIDTH-1:0] r_cnt;
   logic [LWIDTH-1:0] r_len;
   logic [LWIDTH-1:0] len;
   logic [LWIDTH-1:0] out_len_q;

   logic              acc_full;
   logic              accept;
   logic              last_word;
   logic              flush_close;
   logic              complete;
   logic              load_merged;
   logic              load_acc;
   logic              latch_len;
   logic              clear_acc;

   // in_ready comes straight from the state register, so out_ready never
   // reaches it combinationally.
   assign acc_full      = (state == BOTH);
   assign bus.out_valid = (state != EMPTY);
   assign bus.in_ready  = !acc_full;
   assign bus.out_len   = out_len_q;

   assign accept      = bus.in_valid && !acc_full;
   assign last_word   = accept && (r_cnt == LWIDTH'(CORE - 1));
   // A flush only closes a vector that has at least one word, counting a word
   // accepted in the same cycle; a flush on the lane CORE-1 word merges with it.
   assign flush_close = bus.flush && !acc_full && ((r_cnt != '0) || accept);
   assign complete    = last_word || flush_close;
   assign len         = r_cnt + LWIDTH'(accept);
   assign clear_acc   = load_merged || load_acc;

   // Slot occupancy register.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Slot occupancy next state and datapath strobes. load_merged moves the
   // vector being completed this cycle (acc plus the same-cycle word) into the
   // output stage; load_acc moves a vector parked in acc; latch_len remembers
   // the length of a vector that has to park.
   always_comb begin
      state_next  = state;
      load_merged = 1'b0;
      load_acc    = 1'b0;
      latch_len   = 1'b0;
      unique case (state)
         EMPTY: begin
            if (complete) begin
               state_next  = OUT_ONLY;
               load_merged = 1'b1;
            end
         end
         OUT_ONLY: begin
            if (complete) begin
               if (bus.out_ready) begin
                  load_merged = 1'b1;
               end else begin
                  state_next = BOTH;
                  latch_len  = 1'b1;
               end
            end else if (bus.out_ready) begin
               state_next = EMPTY;
            end
         end
         BOTH: begin
            if (bus.out_ready) begin
               state_next = OUT_ONLY;
               load_acc   = 1'b1;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // Write pointer into acc; it restarts whenever acc is handed to the output.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         r_cnt <= '0;
      end else if (clear_acc) begin
         r_cnt <= '0;
      end else if (accept) begin
         r_cnt <= len;
      end
   end

   // Length of the vector parked in acc while the output stage is busy.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         r_len <= '0;
      end else if (latch_len) begin
         r_len <= len;
      end
   end

   // Length reported with the vector in the output stage; held after a drain.
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         out_len_q <= '0;
      end else if (load_merged) begin
         out_len_q <= len;
      end else if (load_acc) begin
         out_len_q <= r_len;
      end
   end

   // One accumulate register and one output register per lane.
   for (genvar k = 0; k < CORE; k++) begin : g_lane
      logic  lane_sel;
      word_t acc_q;
      word_t out_q;

      assign lane_sel        = accept && (r_cnt == LWIDTH'(k));
      assign bus.out_data[k] = out_q;

      // Accumulate lane: captures its word, and is zeroed on every transfer so
      // lanes a flushed vector never reached read as zero padding.
      always_ff @(posedge clk or negedge xrst) begin
         if (!xrst) begin
            acc_q <= '0;
         end else if (clear_acc) begin
            acc_q <= '0;
         end else if (lane_sel) begin
            acc_q <= bus.in_data;
         end
      end

      // Output lane: takes acc, with the same-cycle word bypassed in when the
      // completing word targets this lane.
      always_ff @(posedge clk or negedge xrst) begin
         if (!xrst) begin
            out_q <= '0;
         end else if (load_merged) begin
            out_q <= lane_sel ? bus.in_data : acc_q;
         end else if (load_acc) begin
            out_q <= acc_q;
         end
      end
   end

endmodule

// File: tb/tb_gobou_deserial_vec.sv
// Self-checking bench for gobou_deserial_vec with a queue-based reference model.
module tb_gobou_deserial_vec;
   import gobou_deserial_vec_pkg::*;

   typedef struct {
      word_t lane [CORE];
      int    len;
   } vec_t;

   logic clk  = 1'b0;
   logic xrst = 1'b1;

   gobou_deserial_vec_if bus ();

   gobou_deserial_vec dut (
      .clk  (clk),
      .xrst (xrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: completed vectors awaiting consumption (at most two)
   // and the words of the vector currently being collected.
   vec_t  exp_q [$];
   word_t part  [$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      part.delete();
   endtask

   // One clock edge of the model: the consumer pops, the stream pushes a word,
   // and a full or flushed partial vector becomes a new entry.
   task automatic model_edge(input logic v, input word_t d, input logic f, input logic r);
      automatic bit full = (exp_q.size() == 2);
      automatic bit acc  = v && !full;
      vec_t nv;
      if (exp_q.size() > 0 && r) void'(exp_q.pop_front());
      if (acc) part.push_back(d);
      if (part.size() == CORE || (f && !full && part.size() > 0)) begin
         for (int k = 0; k < CORE; k++) nv.lane[k] = (k < part.size()) ? part[k] : word_t'(0);
         nv.len = part.size();
         exp_q.push_back(nv);
         part.delete();
      end
   endtask

   task automatic checkOutput();
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q.size() < 2});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
         check("out_len", 32'(bus.out_len), 32'(exp_q[0].len));
         for (int k = 0; k < CORE; k++)
            check($sformatf("out_data%0d", k), 32'(bus.out_data[k]), 32'(exp_q[0].lane[k]));
      end
   endtask

   task automatic check_reset_zero();
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_len", 32'(bus.out_len), 32'd0);
      for (int k = 0; k < CORE; k++)
         check($sformatf("rst_out_data%0d", k), 32'(bus.out_data[k]), 32'd0);
   endtask

   // Drive one cycle of inputs just after a falling edge, update the model on
   // the rising edge and compare on the next falling edge.
   task automatic applyStimulus(input logic v, input word_t d, input logic f, input logic r);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.flush     = f;
      bus.out_ready = r;
      #1;
      check("in_ready_pre_edge", {31'd0, bus.in_ready}, {31'd0, exp_q.size() < 2});
      @(posedge clk);
      model_edge(v, d, f, r);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, r);
   endtask

   initial begin : global_timeout
      #500000;
      $display("[TB] FAIL timeout simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int n;
      int cyc;
      bit full;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state.
      #1 xrst = 1'b0;
      #1 check_reset_zero();
      @(negedge clk);
      @(negedge clk);
      xrst = 1'b1;
      model_reset();
      checkOutput();

      // Sustained stream 1..16 with the consumer always ready.
      $display("[TB] sustained stream");
      for (int k = 0; k < CORE; k++) applyStimulus(1'b1, word_t'(k + 1), 1'b0, 1'b1);
      idle(2, 1'b1);

      // Back-pressure: 48 words -1..-48, consumer released at cycle 40.
      $display("[TB] back-pressure");
      n   = 0;
      cyc = 0;
      while (n < 48 && cyc < 200) begin
         full = (exp_q.size() == 2);
         applyStimulus(1'b1, word_t'(-(n + 1)), 1'b0, cyc >= 40);
         if (!full) n++;
         cyc++;
      end
      check("bp_words_sent", 32'(n), 32'd48);
      idle(4, 1'b1);

      // Flushed short vector with extreme values, then an empty flush.
      $display("[TB] flush");
      applyStimulus(1'b1, word_t'(16'h7FFF), 1'b0, 1'b1);
      applyStimulus(1'b1, word_t'(16'h8000), 1'b0, 1'b1);
      applyStimulus(1'b1, word_t'(3), 1'b0, 1'b1);
      applyStimulus(1'b1, word_t'(4), 1'b0, 1'b1);
      applyStimulus(1'b1, word_t'(5), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      idle(2, 1'b1);

      // Flush coinciding with the lane CORE-1 word.
      for (int k = 0; k < CORE - 1; k++) applyStimulus(1'b1, word_t'(100 + k), 1'b0, 1'b1);
      applyStimulus(1'b1, word_t'(115), 1'b1, 1'b1);
      idle(2, 1'b1);

      // Flush while acc holds a parked vector.
      for (int k = 0; k < 2 * CORE; k++) applyStimulus(1'b1, word_t'(200 + k), 1'b0, 1'b0);
      applyStimulus(1'b1, word_t'(999), 1'b1, 1'b0);
      idle(3, 1'b1);

      // Reset in the middle of a vector.
      $display("[TB] reset mid-vector");
      for (int k = 0; k < 7; k++) applyStimulus(1'b1, word_t'(50 + k), 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      #2 xrst = 1'b0;
      #1 check_reset_zero();
      model_reset();
      @(negedge clk);
      check_reset_zero();
      xrst = 1'b1;
      for (int k = 0; k < CORE; k++) applyStimulus(1'b1, word_t'(300 + k), 1'b0, 1'b0);
      idle(2, 1'b1);

      // Loopback from a lane-0-first vector shifter holding -8..7.
      $display("[TB] loopback");
      for (int k = 0; k < CORE; k++) applyStimulus(1'b1, word_t'(k - 8), 1'b0, 1'b0);
      idle(1, 1'b0);
      idle(2, 1'b1);

      // Randomised traffic.
      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++)
         applyStimulus($urandom_range(0, 3) != 0, word_t'($urandom),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      idle(4, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gobou_deserial_vec.md
# gobou_deserial_vec

Serial-to-parallel vector collector for the gobou fully-connected core: accepts a stream of DWIDTH words one per cycle and assembles them into a CORE-lane parallel vector, the inverse of the serial vector shifter that drains core outputs lane 0 first. Sits between the DMA/input-buffer read path and the per-core input registers. It is double-buffered, with an accumulate stage and an output stage, so input streaming continues while a completed vector awaits consumption. Ready/valid handshakes on both sides and an explicit flush for short (zero-padded) tail vectors.

## Interface
Parameters (from `gobou.vh`):
- DWIDTH, 16: signed word width.
- CORE, 16: lanes per vector; fixed at 16 by the port list.
- LWIDTH, 10: counter width; must be at least clog2(CORE)+1.

Ports:
- clk  in  1  clock; all state on rising edge.
- xrst  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  in_data holds a word.
- in_ready  out  1  block can accept; combinational, equal to !acc_full.
- in_data  in  DWIDTH signed  serial word.
- flush  in  1  single-cycle pulse; close the current partial vector.
- out_valid  out  1  out_data0..15 and out_len hold a vector.
- out_ready  in  1  consumer takes the vector.
- out_data0 … out_data15  out  DWIDTH signed each  vector lanes; lane k holds the k-th accepted word.
- out_len  out  LWIDTH  number of valid lanes, 1..CORE; lanes at or above out_len are 0.

## Operation
- Accept: a word is accepted when in_valid && in_ready. The word is written to acc lane r_cnt, then r_cnt increments.
- Completion: a vector completes when an accepted word lands in lane CORE-1, or when flush is seen with r_cnt>0. In both cases len = number of words in the vector, with the same-cycle word included.
- Transfer condition: the output slot is free if !out_valid, or if out_valid && out_ready in that cycle.
- On completion with the slot free:
  - the output registers load the vector, with the same-cycle word merged in;
  - out_valid <= 1 and out_len <= len;
  - acc is cleared to 0 and r_cnt <= 0.
- On completion with the slot busy:
  - acc_full <= 1 and r_len <= len, so in_ready drops;
  - acc is transferred on the first cycle the slot frees, which clears acc, r_cnt and acc_full.
- Drain: out_valid && out_ready with nothing to transfer gives out_valid <= 0. out_data and out_len hold their values; they are don't-care while !out_valid.
- Zero padding: acc is cleared on every transfer, so unwritten lanes of a flushed vector read 0.
- Flush edge cases:
  - flush with r_cnt==0 and no word accepted: no effect.
  - flush while acc_full: ignored.
  - flush on the cycle that fills lane CORE-1: one vector with len=CORE, no extra empty vector.
- Simultaneous events: a drain and a transfer in the same cycle are legal. out_valid stays 1 and the new vector replaces the old one.
- Reset (asynchronous, at any time, including mid-vector):
  - all lanes, acc, r_cnt, r_len and acc_full go to 0;
  - out_valid=0, out_len=0, out_data*=0, in_ready=1;
  - any partial vector is discarded.
- Data is stored bit-exact (signed, no extension or saturation).

## Timing
- Latency: last word (or flush) at edge t gives out_valid=1 after edge t, provided the slot is free.
- Throughput: with out_ready held 1, one word per cycle is sustained, one vector every CORE cycles, and in_ready never deasserts.
- Back-pressure: with out_valid=1 and out_ready=0, CORE further words are accepted, then in_ready=0 until the first out_ready cycle. in_ready returns to 1 in the cycle after that handshake.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.

## Structure
- DWIDTH, CORE and LWIDTH come from the shared header `gobou.vh`; no new typedefs are needed.
- No sub-module. Lanes are built by a generate loop over CORE: acc register, output register, and the lane-write decode `r_cnt == k`.
- Control is r_cnt, acc_full, r_len and out_valid. It is effectively a two-slot FIFO with states EMPTY, OUT_ONLY and BOTH, encoded by {acc_full, out_valid}.

## Test plan
- Sustained stream: words 1..16, in_valid=1, out_ready=1 → out_valid one cycle after word 16, lane k = k+1, out_len=16; in_ready constantly 1.
- Back-pressure: 48 words, −1..−48, with out_ready=0 until cycle 40 → first vector −1..−16 held stable; in_ready=0 after word 32; vectors 2 and 3 delivered in order after release, with no loss or duplication.
- Flush: 5 words 0x7FFF, 0x8000, 3, 4, 5, then flush → out_len=5, lanes 0..4 match, lanes 5..15 = 0. Flush with r_cnt=0 → no out_valid.
- Flush coinciding with word 16 → exactly one vector, out_len=16. Flush while acc_full → ignored.
- Reset mid-vector: xrst low after 7 words → all outputs 0, in_ready=1. Next 16 words form a clean vector with no stale lanes.
- Loopback: drive the serial vector shifter with vector −8..7, feed its output with in_valid high for 16 cycles → identical vector at out_data0..15.
